// File: rtl/avmm_gpio_pkg.sv
// ecu_gpio_pkg -- shared constants for the Avalon-MM GPIO block.
//   MAX_WIDTH : widest supported GPIO bank (one 32-bit data word)
//   ADDR_W    : width of the word address on the register bus
//   DATA_W    : width of the register bus data
//   reg_off_e : word offsets of the eight registers
package ecu_gpio_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 32;

  typedef enum logic [ADDR_W-1:0] {
    REG_DATA     = 3'd0,
    REG_DIR      = 3'd1,
    REG_IRQ_MASK = 3'd2,
    REG_EDGE_CAP = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLR   = 3'd5,
    REG_RISE_EN  = 3'd6,
    REG_FALL_EN  = 3'd7
  } reg_off_e;

endpackage

// File: rtl/avmm_gpio_if.sv
// avmm_gpio_if -- Avalon-MM slave register bus for the GPIO block.
//   avs_address       : word address (master -> slave)
//   avs_read          : single-cycle read strobe (master -> slave)
//   avs_write         : single-cycle write strobe (master -> slave)
//   avs_writedata     : write data (master -> slave)
//   avs_readdata      : registered read data (slave -> master)
//   avs_readdatavalid : read data qualifier (slave -> master)
//
// Handshake: there is no waitrequest, so every strobe is accepted in the
// cycle it is high. Each accepted read produces exactly one cycle of
// avs_readdatavalid on the following cycle, with avs_readdata valid in that
// same cycle. Read and write may be asserted together; the read returns the
// register contents from before the write.
interface avmm_gpio_if;
  import ecu_gpio_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/avmm_gpio_sync.sv
// gpio_sync -- multi-flop synchroniser for asynchronous GPIO pins.
//   clk     : sampling clock
//   rst     : synchronous active-high reset, clears every stage
//   i_async : asynchronous pin inputs
//   o_sync  : pins after STAGES flops, safe to use in the clk domain
module gpio_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/avmm_gpio.sv
// avmm_gpio -- Avalon-MM GPIO bank with direction control, set/clear
// output aliases and edge-capture interrupts.
//   clk_clk     : sole clock, rising edge
//   reset_reset : synchronous active-high reset
//   avs         : register bus (slave side), 1-cycle read latency
//   gpio_in     : asynchronous pin inputs
//   gpio_out    : output data register
//   gpio_oe     : per-bit output enable (1 = drive), mirrors DIR
//   irq         : registered level interrupt, |(EDGE_CAP & IRQ_MASK)
// WIDTH must lie in 1..32 and SYNC_STAGES in 2..4.
module avmm_gpio
  import ecu_gpio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  avmm_gpio_if.slave       avs,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  r_dir;
  logic [WIDTH-1:0]  r_irq_mask;
  logic [WIDTH-1:0]  r_edge_cap;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_hist;
  logic              r_irq;
  logic [DATA_W-1:0] r_readdata;
  logic              r_readdatavalid;

  logic [WIDTH-1:0]  w_sync;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_new_edge;
  logic [WIDTH-1:0]  w_cap_clr;
  logic [WIDTH-1:0]  w_cap_next;
  logic [WIDTH-1:0]  w_rd_val;
  logic [DATA_W-1:0] w_rd_word;
  reg_off_e          w_addr;
  logic              w_unused_wdata;

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_async (gpio_in),
    .o_sync  (w_sync)
  );

  assign w_addr  = reg_off_e'(avs.avs_address);
  assign w_wdata = avs.avs_writedata[WIDTH-1:0];
  // Bits WIDTH..31 of writedata are deliberately ignored.
  assign w_unused_wdata = &{1'b0, avs.avs_writedata};

  // Edges are taken between the synchroniser output and one extra history
  // flop; output-direction bits never capture.
  assign w_rise     = w_sync & ~r_hist;
  assign w_fall     = ~w_sync & r_hist;
  assign w_new_edge = ((w_rise & r_rise_en) | (w_fall & r_fall_en)) & ~r_dir;

  // Write-1-to-clear; a fresh edge on the same bit overrides the clear.
  assign w_cap_clr  = (avs.avs_write && w_addr == REG_EDGE_CAP) ? w_wdata : '0;
  assign w_cap_next = (r_edge_cap & ~w_cap_clr) | w_new_edge;

  always_comb begin
    w_rd_val = '0;
    case (w_addr)
      // Input bits come from the synchroniser, never straight from the pins.
      REG_DATA:     w_rd_val = (w_sync & ~r_dir) | (r_out & r_dir);
      REG_DIR:      w_rd_val = r_dir;
      REG_IRQ_MASK: w_rd_val = r_irq_mask;
      REG_EDGE_CAP: w_rd_val = r_edge_cap;
      REG_OUTSET:   w_rd_val = '0;
      REG_OUTCLR:   w_rd_val = '0;
      REG_RISE_EN:  w_rd_val = r_rise_en;
      REG_FALL_EN:  w_rd_val = r_fall_en;
      default:      w_rd_val = '0;
    endcase
    w_rd_word = '0;
    w_rd_word[WIDTH-1:0] = w_rd_val;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_out           <= OUT_RESET;
      r_dir           <= '0;
      r_irq_mask      <= '0;
      r_edge_cap      <= '0;
      r_rise_en       <= '0;
      r_fall_en       <= '0;
      r_hist          <= '0;
      r_irq           <= 1'b0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      if (avs.avs_write) begin
        case (w_addr)
          REG_DATA:     r_out      <= w_wdata;
          REG_DIR:      r_dir      <= w_wdata;
          REG_IRQ_MASK: r_irq_mask <= w_wdata;
          REG_OUTSET:   r_out      <= r_out | w_wdata;
          REG_OUTCLR:   r_out      <= r_out & ~w_wdata;
          REG_RISE_EN:  r_rise_en  <= w_wdata;
          REG_FALL_EN:  r_fall_en  <= w_wdata;
          default:      ; // EDGE_CAP clear is folded into w_cap_next
        endcase
      end
      r_hist          <= w_sync;
      r_edge_cap      <= w_cap_next;
      r_irq           <= |(r_edge_cap & r_irq_mask);
      r_readdatavalid <= avs.avs_read;
      // The mux sees pre-write register values, so a same-cycle read
      // returns the old contents.
      if (avs.avs_read) r_readdata <= w_rd_word;
    end
  end

  assign gpio_out              = r_out;
  assign gpio_oe               = r_dir;
  assign irq                   = r_irq;
  assign avs.avs_readdata      = r_readdata;
  assign avs.avs_readdatavalid = r_readdatavalid;

endmodule
